apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time on a valid/ready port, runs the
// SETUP/ACCESS handshake, and returns a single-cycle response with error/timeout flags.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    // Wait count at which the next low-pready edge is the TIMEOUT-th one.
    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d   = StSetup;
                    wait_d    = 8'd0;
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_write ? cmd_wdata : 32'h0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (pready) begin
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? 32'h0 : prdata;
                end else if (wait_q == LastWait) begin
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = 32'h0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= StIdle;
            wait_q        <= 8'd0;
            paddr_q       <= 32'h0;
            pwdata_q      <= 32'h0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pwrite      = pwrite_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scripted completer, response scoreboard, and per-scenario tasks.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [31:0] prdata = 32'h0;

    apb_master #(.TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];   // {rdata, err, timeout}

    // Completer behaviour knobs; prdata = slv_rdata ^ paddr so each address is distinct.
    logic [31:0] slv_rdata = 32'hC90FDAA2;
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic        slv_hold = 1'b0;

    task automatic completer();
        int acc = 0;
        forever begin
            @(negedge pclk);
            if (preset || !(psel && penable)) begin
                acc = 0;
                pready = 1'b0;
                pslverr = 1'($urandom);
                prdata = $urandom;
            end else begin
                pready = !slv_hold && (acc == slv_wait);
                prdata = pready ? (slv_rdata ^ paddr) : $urandom;
                pslverr = pready ? slv_err : 1'($urandom);
                acc++;
            end
        end
    endtask

    task automatic monitor();
        logic [33:0] e;
        forever begin
            @(negedge pclk);
            if (!preset && rsp_valid) begin
                checks++;
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: got rdata=%h err=%b to=%b, required none",
                             rsp_rdata, rsp_err, rsp_timeout);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
                        failures++;
                        $display("FAIL rsp_data: got rdata=%h err=%b to=%b, required rdata=%h err=%b to=%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e[33:2], e[1], e[0]);
                    end
                end
            end
        end
    endtask

    task automatic counter();
        forever begin
            @(posedge pclk);
            cyc++;
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge pclk);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge pclk);
            n++;
        end
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_xfer(input string name, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] er, input logic ee,
                            input logic et, input int exp_psel);
        int pc = 0;
        int n;
        logic [31:0] epwd;
        epwd = w ? d : 32'h0;
        exp_q.push_back({er, ee, et});
        send(w, a, d);
        for (n = 0; n < 100; n++) begin
            @(negedge pclk);
            if (rsp_valid) break;
            if (psel) begin
                pc++;
                checks++;
                if ({paddr, pwrite, pwdata} !== {a, w, epwd}) begin
                    failures++;
                    $display("FAIL %s_hold: got addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                             name, paddr, pwrite, pwdata, a, w, epwd);
                end
            end
        end
        checks++;
        if (n >= 100 || pc != exp_psel || psel !== 1'b0 || penable !== 1'b0 || paddr !== a) begin
            failures++;
            $display("FAIL %s_timing: got psel_cycles=%0d psel=%b penable=%b addr=%h, required %0d 0 0 %h",
                     name, pc, psel, penable, paddr, exp_psel, a);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pulse: got rsp_valid=%b pending=%0d, required 0 0",
                     name, rsp_valid, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
        end
        checks++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0",
                     paddr, pwdata, rsp_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b, required 1", cmd_ready);
        end
        repeat (2) @(negedge pclk);
        preset = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        slv_wait = 0; slv_err = 1'b0; slv_hold = 1'b0;
        run_xfer("read0", 1'b0, 32'h0, 32'hDEADBEEF, 32'hC90FDAA2, 1'b0, 1'b0, 2);
    endtask

    task automatic test_write_wait();
        slv_wait = 3;
        run_xfer("write3", 1'b1, 32'h4, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 5);
        slv_wait = 0;
    endtask

    task automatic test_slverr();
        slv_err = 1'b1;
        run_xfer("slverr", 1'b0, 32'h10, 32'h0, slv_rdata ^ 32'h10, 1'b1, 1'b0, 2);
        slv_err = 1'b0;
    endtask

    task automatic test_timeout();
        slv_hold = 1'b1;
        run_xfer("timeout", 1'b0, 32'hC, 32'h0, 32'h0, 1'b1, 1'b1, 17);
        slv_hold = 1'b0;
        slv_wait = 15;
        run_xfer("ready_last", 1'b0, 32'h8, 32'h0, slv_rdata ^ 32'h8, 1'b0, 1'b0, 17);
        slv_wait = 0;
    endtask

    task automatic test_back_to_back();
        int t[3];
        int base;
        int n;
        base = rsp_seen;
        for (int i = 0; i < 3; i++) exp_q.push_back({slv_rdata ^ 32'(i), 1'b0, 1'b0});
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_addr = 32'(i);
            n = 0;
            while (!cmd_ready && n < 20) begin
                @(negedge pclk);
                n++;
            end
            @(posedge pclk);
            #1 t[i] = cyc;
        end
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_seen < base + 3 && n < 30) begin
            @(negedge pclk);
            #1 n++;
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (t[i] - t[i-1] != 3) begin
                failures++;
                $display("FAIL b2b_gap%0d: got %0d cycles, required 3", i, t[i] - t[i-1]);
            end
        end
        checks++;
        if (rsp_seen - base != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d responses pending=%0d, required 3 0",
                     rsp_seen - base, exp_q.size());
        end
    endtask

    task automatic test_reset_in_access();
        int base;
        slv_hold = 1'b1;
        send(1'b1, 32'h20, 32'h12345678);
        repeat (3) @(negedge pclk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            failures++;
            $display("FAIL rst_pre: got psel/penable=%b, required 11", {psel, penable});
        end
        base = rsp_seen;
        #2 preset = 1'b1;
        #1;
        checks++;
        if ({psel, penable, pwrite} !== 3'b0 || {paddr, pwdata} !== 64'h0) begin
            failures++;
            $display("FAIL rst_async: got psel=%b en=%b wr=%b addr=%h wdata=%h, required 0",
                     psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge pclk);
        preset = 1'b0;
        slv_hold = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready: got %b, required 1", cmd_ready);
        end
        repeat (6) @(negedge pclk);
        #1;
        checks++;
        if (rsp_seen != base || psel !== 1'b0) begin
            failures++;
            $display("FAIL rst_norsp: got %0d responses psel=%b, required 0 0",
                     rsp_seen - base, psel);
        end
        run_xfer("post_rst", 1'b0, 32'h30, 32'h0, slv_rdata ^ 32'h30, 1'b0, 1'b0, 2);
    endtask

    initial begin
        fork
            completer();
            monitor();
            counter();
        join_none
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_in_access();
        repeat (3) @(negedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
